// File: rtl/sdram_arbiter_if.sv
// Signal bundle linking the icache (p0) and dcache (p1) miss paths, the arbiter
// and the SDRAM block-transfer controller (mem_*).
interface sdram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
);
  logic              p0_req, p1_req;
  logic              p0_we, p1_we;
  logic [ADDR_W-1:0] p0_add, p1_add;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic              p0_gnt, p1_gnt;
  logic              p0_done, p1_done;
  logic [DATA_W-1:0] rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_add;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_accept;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_add, p1_add, p0_wdata, p1_wdata,
    input  mem_ready, mem_accept, mem_rvalid, mem_rdata,
    output p0_gnt, p1_gnt, p0_done, p1_done, rdata,
    output mem_req, mem_we, mem_add, mem_wdata
  );

  // Cache controllers plus SDRAM controller side.
  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_add, p1_add, p0_wdata, p1_wdata,
    output mem_ready, mem_accept, mem_rvalid, mem_rdata,
    input  p0_gnt, p1_gnt, p0_done, p1_done, rdata,
    input  mem_req, mem_we, mem_add, mem_wdata
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of the SDRAM block controller. Define SDRAM_ARB_RR_EN
// for round-robin tie-breaking; otherwise port 1 (dcache) wins every tie.
module sdram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  sdram_arbiter_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_add_q, mem_add_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0]        req;
  logic              winner;

  assign req = {bus.p1_req, bus.p0_req};

`ifdef SDRAM_ARB_RR_EN
  logic ptr_q, ptr_d;

  assign winner = (&req) ? ptr_q : req[1];
  assign ptr_d  = (state_q == DONE) ? ~owner_q : ptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end
`else
  assign winner = req[1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      gnt_q       <= '0;
      done_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_add_q   <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values of the others.
      state_q     <= state_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_add_q   <= mem_add_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = ISSUE;
      ISSUE:   if (bus.mem_accept) state_d = BUSY;
      BUSY:    if (bus.mem_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: hold values assigned up front so no branch leaves a register undriven (no latches).
    owner_d     = owner_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_add_d   = mem_add_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d     = winner;
          gnt_d       = winner ? 2'b10 : 2'b01;
          mem_req_d   = 1'b1;
          mem_we_d    = winner ? bus.p1_we    : bus.p0_we;
          mem_add_d   = winner ? bus.p1_add   : bus.p0_add;
          mem_wdata_d = winner ? bus.p1_wdata : bus.p0_wdata;
        end
      end
      // A refresh shows up as mem_ready low with no accept; mem_req simply stays up.
      ISSUE: if (bus.mem_accept) mem_req_d = 1'b0;
      BUSY: begin
        if (bus.mem_rvalid) rdata_d = bus.mem_rdata;
        if (bus.mem_ready)  done_d[owner_q] = 1'b1;
      end
      DONE:    gnt_d = '0;
      default: ;
    endcase
  end

  assign bus.p0_gnt    = gnt_q[0];
  assign bus.p1_gnt    = gnt_q[1];
  assign bus.p0_done   = done_q[0];
  assign bus.p1_done   = done_q[1];
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_add   = mem_add_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: behavioural SDRAM controller, transaction-level
// scoreboard, directed vector table, hand sequences and a randomized phase.
module tb_sdram_arbiter;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int CTL_LAT = 3;
`ifdef SDRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Controller model: accept when idle and requested, busy CTL_LAT cycles,
  // read data in the cycle before ready returns.
  int          ctl_busy, ctl_refresh;
  logic        ctl_we;
  logic [DW-1:0] ctl_data, ctl_next_data;
  bit          acc_given;

  // Transaction scoreboard.
  bit          owned, accepted, post_done, own_p, cur_we, rr_ptr;
  logic [AW-1:0] cur_add;
  logic [DW-1:0] cur_wdata, exp_rdata;
  int          age;
  int          grant_log[$];

  bit          auto_mode, refresh_rand;
  int          raise_pct;

  typedef struct {
    bit            port;
    bit            we;
    logic [AW-1:0] add;
    logic [DW-1:0] wdata;
    logic [DW-1:0] ret;
    int            refresh;
    bit            mutate;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic drive_port(input bit p, input bit req, input bit we,
                            input logic [AW-1:0] add, input logic [DW-1:0] wdata);
    if (p) begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_add = add; bus.p1_wdata = wdata;
    end else begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_add = add; bus.p0_wdata = wdata;
    end
  endtask

  task automatic model_reset();
    ctl_busy = 0; ctl_refresh = 0; acc_given = 0;
    bus.mem_accept = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_ready = 1'b1;
    owned = 0; accepted = 0; post_done = 0; rr_ptr = 0; age = 0;
    exp_rdata = '0;
  endtask

  task automatic ctl_tick();
    bus.mem_accept = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = {$urandom, $urandom};
    if (ctl_busy > 0) begin
      ctl_busy--;
      bus.mem_ready = (ctl_busy == 0);
      if (ctl_busy == 1 && !ctl_we) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = ctl_data;
      end
    end else if (ctl_refresh > 0) begin
      ctl_refresh--;
      bus.mem_ready = 1'b0;
    end else if (bus.mem_req) begin
      bus.mem_accept = 1'b1;
      bus.mem_ready  = 1'b0;
      ctl_busy       = CTL_LAT;
      ctl_we         = bus.mem_we;
      ctl_data       = ctl_next_data;
      ctl_next_data  = {$urandom, $urandom};
      acc_given      = 1;
    end else begin
      bus.mem_ready = 1'b1;
    end
  endtask

  task automatic idle_checks();
    check("idle_outs", {61'd0, bus.p1_done, bus.p0_done, bus.mem_req}, 64'd0);
    check("idle_rdata", bus.rdata, exp_rdata);
  endtask

  task automatic monitor();
    logic [1:0] gnt, done, req, onehot;
    bit exp_p;
    gnt  = {bus.p1_gnt, bus.p0_gnt};
    done = {bus.p1_done, bus.p0_done};
    req  = {bus.p1_req, bus.p0_req};
    if (!rst) begin
      check("reset_ctrl", {58'd0, gnt, done, bus.mem_req, bus.mem_we}, 64'd0);
      check("reset_data", bus.rdata | bus.mem_wdata | 64'(bus.mem_add), 64'd0);
      return;
    end
    if (acc_given) begin
      accepted  = 1;
      acc_given = 0;
    end
    if (post_done) begin
      check("post_done_gnt", 64'(gnt), 64'd0);
      idle_checks();
      post_done = 0;
    end else if (!owned) begin
      if (gnt != 2'b00) begin
        exp_p = (req == 2'b11) ? (RR ? rr_ptr : 1'b1) : req[1];
        check("grant_has_req", 64'(req != 2'b00), 64'd1);
        check("grant_port", 64'(gnt), exp_p ? 64'd2 : 64'd1);
        owned = 1; own_p = exp_p; accepted = 0; age = 0;
        cur_we    = exp_p ? bus.p1_we    : bus.p0_we;
        cur_add   = exp_p ? bus.p1_add   : bus.p0_add;
        cur_wdata = exp_p ? bus.p1_wdata : bus.p0_wdata;
        grant_log.push_back(int'(bus.p1_gnt));
      end else begin
        idle_checks();
      end
    end
    if (owned) begin
      age++;
      onehot = own_p ? 2'b10 : 2'b01;
      check("gnt_hold", 64'(gnt), 64'(onehot));
      check("mem_add", 64'(bus.mem_add), 64'(cur_add));
      check("mem_we", 64'(bus.mem_we), 64'(cur_we));
      check("mem_wdata", bus.mem_wdata, cur_wdata);
      check("mem_req", 64'(bus.mem_req), 64'(!accepted));
      if (done != 2'b00) begin
        check("done_port", 64'(done), 64'(onehot));
        check("done_after_accept", 64'(accepted), 64'd1);
        if (!cur_we) exp_rdata = ctl_data;
        check("done_rdata", bus.rdata, exp_rdata);
        rr_ptr = ~own_p; owned = 0; post_done = 1;
      end else if (age == 60) begin
        check("xfer_timeout", 64'(done), 64'(onehot));
        owned = 0;
      end
    end
  endtask

  task automatic requesters();
    for (int p = 0; p < 2; p++) begin
      bit r, d;
      r = (p == 1) ? bus.p1_req  : bus.p0_req;
      d = (p == 1) ? bus.p1_done : bus.p0_done;
      if (r && d)
        drive_port(p == 1, 1'b0, 1'b0, '0, '0);
      else if (!r && int'($urandom_range(99)) < raise_pct)
        drive_port(p == 1, 1'b1, 1'($urandom), 16'($urandom), {$urandom, $urandom});
    end
    if (refresh_rand && ctl_busy == 0 && ctl_refresh == 0 && $urandom_range(15) == 0)
      ctl_refresh = int'($urandom_range(1, 3));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    monitor();
    if (!rst) model_reset();
    else      ctl_tick();
    if (auto_mode) requesters();
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int cyc;
    bit got, other;
    logic [DW-1:0] rd;
    drive_port(v.port, 1'b1, v.we, v.add, v.wdata);
    ctl_next_data = v.ret;
    ctl_refresh   = v.refresh;
    got = 0; other = 0; cyc = 0; rd = '0;
    while (!got && cyc < 60) begin
      step();
      cyc++;
      if (v.mutate && accepted) drive_port(v.port, 1'b1, v.we, 16'hFFFF, 64'h0);
      if (v.port ? bus.p0_gnt : bus.p1_gnt) other = 1;
      if (v.port ? bus.p1_done : bus.p0_done) begin
        got = 1;
        rd  = bus.rdata;
      end
    end
    drive_port(v.port, 1'b0, v.we, v.add, v.wdata);
    check($sformatf("%s_done", tag), 64'(got), 64'd1);
    check($sformatf("%s_latency", tag), 64'(cyc), 64'(2 + v.refresh + CTL_LAT));
    check($sformatf("%s_rdata", tag), rd, v.exp_rdata);
    check($sformatf("%s_other_gnt", tag), 64'(other), 64'd0);
    step();
    step();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t required < 200000", $time);
    $fatal(1);
  end

  initial begin
    int cyc;
    vecs[0] = '{1'b0, 1'b0, 16'h1234, 64'h0, 64'hDEAD_BEEF_0123_4567, 0, 1'b0, 64'hDEAD_BEEF_0123_4567};
    vecs[1] = '{1'b1, 1'b1, 16'h0A00, 64'h1111_2222_3333_4444, 64'hAAAA_AAAA_AAAA_AAAA, 0, 1'b0,
                64'hDEAD_BEEF_0123_4567};
    vecs[2] = '{1'b0, 1'b0, 16'h0042, 64'h0, 64'h0123_4567_89AB_CDEF, 4, 1'b0, 64'h0123_4567_89AB_CDEF};
    vecs[3] = '{1'b1, 1'b0, 16'h0BEE, 64'h0, 64'hCAFE_F00D_1234_5678, 0, 1'b1, 64'hCAFE_F00D_1234_5678};
    vecs[4] = '{1'b0, 1'b1, 16'h7777, 64'h5555_6666_7777_8888, 64'h0, 0, 1'b1, 64'hCAFE_F00D_1234_5678};
    vecs[5] = '{1'b1, 1'b1, 16'hFFFE, 64'h0, 64'h9999_9999_9999_9999, 2, 1'b0, 64'hCAFE_F00D_1234_5678};

    rst = 1'b0;
    auto_mode = 0; raise_pct = 0; refresh_rand = 0;
    drive_port(1'b0, 1'b0, 1'b0, '0, '0);
    drive_port(1'b1, 1'b0, 1'b0, '0, '0);
    bus.mem_rdata = '0;
    ctl_next_data = '0;
    model_reset();
    repeat (3) step();
    rst = 1'b1;
    step();
    check("post_reset_gnt", {62'd0, bus.p1_gnt, bus.p0_gnt}, 64'd0);
    check("post_reset_rdata", bus.rdata, 64'd0);

    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Stray accept / read-valid while idle must be ignored.
    bus.mem_accept = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    check("stray_gnt", {62'd0, bus.p1_gnt, bus.p0_gnt}, 64'd0);
    check("stray_rdata", bus.rdata, vecs[5].exp_rdata);

    // Asynchronous reset in the middle of a read.
    drive_port(1'b0, 1'b1, 1'b0, 16'h2222, '0);
    ctl_next_data = 64'h7777_7777_7777_7777;
    cyc = 0;
    while (!accepted && cyc < 20) begin
      step();
      cyc++;
    end
    check("rst_reached_busy", 64'(accepted), 64'd1);
    step();
    #3 rst = 1'b0;
    #1;
    check("rst_async_ctrl", {58'd0, bus.p1_gnt, bus.p0_gnt, bus.p1_done, bus.p0_done,
                             bus.mem_req, bus.mem_we}, 64'd0);
    check("rst_async_data", bus.rdata | bus.mem_wdata | 64'(bus.mem_add), 64'd0);
    drive_port(1'b0, 1'b0, 1'b0, '0, '0);
    step();
    step();
    rst = 1'b1;
    run_vec("after_rst", '{1'b0, 1'b0, 16'h3030, 64'h0, 64'h0F0F_0F0F_0F0F_0F0F, 0, 1'b0,
                           64'h0F0F_0F0F_0F0F_0F0F});

    // Both ports requesting continuously from a fresh reset.
    rst = 1'b0;
    step();
    rst = 1'b1;
    grant_log.delete();
    auto_mode = 1; raise_pct = 100; refresh_rand = 0;
    cyc = 0;
    while (grant_log.size() < 6 && cyc < 200) begin
      step();
      cyc++;
    end
    raise_pct = 0;
    check("tie_grants", 64'(grant_log.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      if (i < grant_log.size())
        check($sformatf("tie_order%0d", i), 64'(grant_log[i]), RR ? 64'(i % 2) : 64'd1);
    cyc = 0;
    while ((bus.p0_req || bus.p1_req || owned || post_done) && cyc < 200) begin
      step();
      cyc++;
    end
    check("tie_drain", {62'd0, bus.p1_req, bus.p0_req}, 64'd0);

    // Randomized traffic with random refresh preemption.
    grant_log.delete();
    raise_pct = 30; refresh_rand = 1;
    repeat (800) step();
    raise_pct = 0;
    cyc = 0;
    while ((bus.p0_req || bus.p1_req || owned || post_done) && cyc < 300) begin
      step();
      cyc++;
    end
    auto_mode = 0;
    check("rand_drain", {62'd0, bus.p1_req, bus.p0_req}, 64'd0);
    check("rand_activity", 64'(grant_log.size() > 20), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
